// File: rtl/leaf_user_bridge.sv
// User-side leaf bridge: one elastic FIFO plus a saturating transfer counter per
// channel, between leaf-interface vld/ack channels and HLS kernel ap_vld/ap_ack ports.
module leaf_user_bridge_chan #(
  parameter int PAYLOAD_BITS    = 32,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int CNT_BITS        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] up_data,
  input  logic                    up_vld,
  output logic                    up_ack,
  output logic [PAYLOAD_BITS-1:0] dn_data,
  output logic                    dn_vld,
  input  logic                    dn_ack,
  output logic [CNT_BITS-1:0]     xfer_count
);
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0]   OCC_FULL = (FIFO_DEPTH_BITS+1)'(DEPTH);
  localparam logic [FIFO_DEPTH_BITS:0]   OCC_ONE  = (FIFO_DEPTH_BITS+1)'(1);
  localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE  = FIFO_DEPTH_BITS'(1);

  logic [PAYLOAD_BITS-1:0]    mem_q [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_BITS:0]   occ_q, occ_d;
  logic [CNT_BITS-1:0]        cnt_q, cnt_d;
  logic                       push, pop;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  // Accept depends only on occupancy and reset, never on upstream valid.
  assign up_ack     = (occ_q != OCC_FULL) && !reset;
  assign dn_vld     = (occ_q != '0);
  assign dn_data    = mem_q[rd_ptr_q];
  assign push       = up_vld && up_ack;
  assign pop        = dn_vld && dn_ack;
  assign xfer_count = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      cnt_d    = sat_inc(cnt_q);
    end
    if (push && !pop)      occ_d = occ_q + OCC_ONE;
    else if (pop && !push) occ_d = occ_q - OCC_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once occupancy clears.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= up_data;
  end
endmodule

module leaf_user_bridge #(
  parameter int PAYLOAD_BITS    = 32,
  parameter int NUM_IN_PORTS    = 1,
  parameter int NUM_OUT_PORTS   = 1,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int CNT_BITS        = 16
) (
  input  logic                                  clk_user,
  input  logic                                  reset,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
  input  logic [NUM_IN_PORTS-1:0]               vld_interface2user,
  output logic [NUM_IN_PORTS-1:0]               ack_user2interface,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  Input_V_V,
  output logic [NUM_IN_PORTS-1:0]               Input_V_V_ap_vld,
  input  logic [NUM_IN_PORTS-1:0]               Input_V_V_ap_ack,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] Output_V_V,
  input  logic [NUM_OUT_PORTS-1:0]              Output_V_V_ap_vld,
  output logic [NUM_OUT_PORTS-1:0]              Output_V_V_ap_ack,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  output logic [NUM_IN_PORTS*CNT_BITS-1:0]      in_xfer_count,
  output logic [NUM_OUT_PORTS*CNT_BITS-1:0]     out_xfer_count
);
  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    leaf_user_bridge_chan #(
      .PAYLOAD_BITS   (PAYLOAD_BITS),
      .FIFO_DEPTH_BITS(FIFO_DEPTH_BITS),
      .CNT_BITS       (CNT_BITS)
    ) u_chan (
      .clk       (clk_user),
      .reset     (reset),
      .up_data   (dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .up_vld    (vld_interface2user[i]),
      .up_ack    (ack_user2interface[i]),
      .dn_data   (Input_V_V[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .dn_vld    (Input_V_V_ap_vld[i]),
      .dn_ack    (Input_V_V_ap_ack[i]),
      .xfer_count(in_xfer_count[i*CNT_BITS +: CNT_BITS])
    );
  end

  for (genvar o = 0; o < NUM_OUT_PORTS; o++) begin : g_out
    leaf_user_bridge_chan #(
      .PAYLOAD_BITS   (PAYLOAD_BITS),
      .FIFO_DEPTH_BITS(FIFO_DEPTH_BITS),
      .CNT_BITS       (CNT_BITS)
    ) u_chan (
      .clk       (clk_user),
      .reset     (reset),
      .up_data   (Output_V_V[o*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .up_vld    (Output_V_V_ap_vld[o]),
      .up_ack    (Output_V_V_ap_ack[o]),
      .dn_data   (din_leaf_user2interface[o*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .dn_vld    (vld_user2interface[o]),
      .dn_ack    (ack_interface2user[o]),
      .xfer_count(out_xfer_count[o*CNT_BITS +: CNT_BITS])
    );
  end
endmodule

// File: tb/tb_leaf_user_bridge.sv
// Scoreboard bench for leaf_user_bridge: one input channel, two output channels,
// depth 4, 4-bit counters so saturation is reachable.
module tb_leaf_user_bridge;
  localparam int PB  = 32;
  localparam int NI  = 1;
  localparam int NO  = 2;
  localparam int FDB = 2;
  localparam int CB  = 4;

  logic              clk_user = 1'b0;
  logic              reset;
  logic [NI*PB-1:0]  dout_leaf_interface2user;
  logic [NI-1:0]     vld_interface2user;
  logic [NI-1:0]     ack_user2interface;
  logic [NI*PB-1:0]  Input_V_V;
  logic [NI-1:0]     Input_V_V_ap_vld;
  logic [NI-1:0]     Input_V_V_ap_ack;
  logic [NO*PB-1:0]  Output_V_V;
  logic [NO-1:0]     Output_V_V_ap_vld;
  logic [NO-1:0]     Output_V_V_ap_ack;
  logic [NO*PB-1:0]  din_leaf_user2interface;
  logic [NO-1:0]     vld_user2interface;
  logic [NO-1:0]     ack_interface2user;
  logic [NI*CB-1:0]  in_xfer_count;
  logic [NO*CB-1:0]  out_xfer_count;

  leaf_user_bridge #(
    .PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO),
    .FIFO_DEPTH_BITS(FDB), .CNT_BITS(CB)
  ) dut (
    .clk_user                (clk_user),
    .reset                   (reset),
    .dout_leaf_interface2user(dout_leaf_interface2user),
    .vld_interface2user      (vld_interface2user),
    .ack_user2interface      (ack_user2interface),
    .Input_V_V               (Input_V_V),
    .Input_V_V_ap_vld        (Input_V_V_ap_vld),
    .Input_V_V_ap_ack        (Input_V_V_ap_ack),
    .Output_V_V              (Output_V_V),
    .Output_V_V_ap_vld       (Output_V_V_ap_vld),
    .Output_V_V_ap_ack       (Output_V_V_ap_ack),
    .din_leaf_user2interface (din_leaf_user2interface),
    .vld_user2interface      (vld_user2interface),
    .ack_interface2user      (ack_interface2user),
    .in_xfer_count           (in_xfer_count),
    .out_xfer_count          (out_xfer_count)
  );

  always #5 clk_user = ~clk_user;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_in_q[$];
  logic [31:0] exp_o0_q[$];
  logic [31:0] exp_o1_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] sat(input int n);
    return (n > 15) ? 32'd15 : 32'(n);
  endfunction

  // Expected words enter the scoreboard at the edge they are accepted upstream.
  always @(negedge clk_user) begin
    if (!reset) begin
      if (vld_interface2user[0] && ack_user2interface[0]) exp_in_q.push_back(dout_leaf_interface2user[31:0]);
      if (Output_V_V_ap_vld[0] && Output_V_V_ap_ack[0]) exp_o0_q.push_back(Output_V_V[31:0]);
      if (Output_V_V_ap_vld[1] && Output_V_V_ap_ack[1]) exp_o1_q.push_back(Output_V_V[63:32]);
    end
  end

  task automatic score(input int sel, input logic [31:0] got);
    logic [31:0] e;
    bit have;
    have = 1'b0;
    e    = '0;
    case (sel)
      0: if (exp_in_q.size() > 0) begin e = exp_in_q.pop_front(); have = 1'b1; end
      1: if (exp_o0_q.size() > 0) begin e = exp_o0_q.pop_front(); have = 1'b1; end
      default: if (exp_o1_q.size() > 0) begin e = exp_o1_q.pop_front(); have = 1'b1; end
    endcase
    if (have) check($sformatf("word_ch%0d", sel), got, e);
    else begin
      tests++;
      fails++;
      $display("FAIL word_ch%0d: got 0x%08h, required no word", sel, got);
    end
  endtask

  // Monitor: compares every downstream transfer against the scoreboard.
  always @(negedge clk_user) begin
    if (!reset) begin
      if (Input_V_V_ap_vld[0] && Input_V_V_ap_ack[0]) score(0, Input_V_V[31:0]);
      if (vld_user2interface[0] && ack_interface2user[0]) score(1, din_leaf_user2interface[31:0]);
      if (vld_user2interface[1] && ack_interface2user[1]) score(2, din_leaf_user2interface[63:32]);
    end
  end

  task automatic tick();
    @(posedge clk_user);
    #1;
  endtask

  task automatic drive(input int sel, input logic [31:0] w, input logic v);
    case (sel)
      0: begin dout_leaf_interface2user = w; vld_interface2user[0] = v; end
      1: begin Output_V_V[31:0] = w; Output_V_V_ap_vld[0] = v; end
      default: begin Output_V_V[63:32] = w; Output_V_V_ap_vld[1] = v; end
    endcase
  endtask

  function automatic logic up_ack(input int sel);
    case (sel)
      0: return ack_user2interface[0];
      1: return Output_V_V_ap_ack[0];
      default: return Output_V_V_ap_ack[1];
    endcase
  endfunction

  function automatic logic dn_vld(input int sel);
    case (sel)
      0: return Input_V_V_ap_vld[0];
      1: return vld_user2interface[0];
      default: return vld_user2interface[1];
    endcase
  endfunction

  task automatic send(input int sel, input logic [31:0] w);
    int t;
    t = 0;
    drive(sel, w, 1'b1);
    @(negedge clk_user);
    while (!up_ack(sel) && t < 20) begin
      @(negedge clk_user);
      t++;
    end
    if (!up_ack(sel)) check("send_timeout", 32'(up_ack(sel)), 32'd1);
    tick();
  endtask

  task automatic stream(input int sel, input logic [31:0] base, input int n, output int gaps);
    gaps = 0;
    for (int i = 0; i < n; i++) begin
      send(sel, base + 32'(i));
      if (!dn_vld(sel)) gaps++;
    end
    drive(sel, '0, 1'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    exp_in_q.delete();
    exp_o0_q.delete();
    exp_o1_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps, acc, k, stall0;
    logic [31:0] w;
    reset = 1'b1;
    dout_leaf_interface2user = '0;
    vld_interface2user       = '0;
    Input_V_V_ap_ack         = '0;
    Output_V_V               = '0;
    Output_V_V_ap_vld        = '0;
    ack_interface2user       = '0;
    tick();
    tick();
    check("rst_ack_in_held", 32'(ack_user2interface), 32'd0);
    check("rst_ack_out_held", 32'(Output_V_V_ap_ack), 32'd0);
    reset = 1'b0;
    #1;
    check("idle_ack_in", 32'(ack_user2interface), 32'd1);
    check("idle_ack_out", 32'(Output_V_V_ap_ack), 32'd3);
    check("idle_vld_in", 32'(Input_V_V_ap_vld), 32'd0);
    check("idle_vld_out", 32'(vld_user2interface), 32'd0);
    check("idle_cnt_in", 32'(in_xfer_count), 32'd0);
    check("idle_cnt_out", 32'(out_xfer_count), 32'd0);
    tick();

    // Streaming 16 words with the kernel always accepting
    Input_V_V_ap_ack = 1'b1;
    stream(0, 32'h1, 16, gaps);
    check("stream_gaps", 32'(gaps), 32'd0);
    tick();
    check("stream_drained_vld", 32'(Input_V_V_ap_vld), 32'd0);
    check("stream_queue_empty", 32'(exp_in_q.size()), 32'd0);
    check("stream_cnt", 32'(in_xfer_count), sat(16));

    // Full/stall: kernel holds off, six words offered
    pulse_reset();
    Input_V_V_ap_ack = 1'b0;
    w = 32'd1;
    acc = 0;
    for (int j = 0; j < 8; j++) begin
      drive(0, w, 1'b1);
      @(negedge clk_user);
      if (ack_user2interface[0]) begin acc++; w = w + 32'd1; end
      tick();
    end
    check("stall_accepted", 32'(acc), 32'd4);
    check("stall_ack_low", 32'(ack_user2interface), 32'd0);
    check("stall_head", Input_V_V, 32'd1);
    Input_V_V_ap_ack = 1'b1;
    #1;
    check("stall_ack_before_pop", 32'(ack_user2interface), 32'd0);
    tick();
    check("stall_ack_after_pop", 32'(ack_user2interface), 32'd1);
    send(0, 32'd5);
    send(0, 32'd6);
    drive(0, '0, 1'b0);
    for (int j = 0; j < 8; j++) tick();
    check("stall_queue_empty", 32'(exp_in_q.size()), 32'd0);
    check("stall_cnt", 32'(in_xfer_count), 32'd6);

    // Channel independence: output channel 1 stalled, channel 0 streams
    pulse_reset();
    ack_interface2user = 2'b01;
    k = 0;
    stall0 = 0;
    gaps = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'hB000_0000 + 32'(i), 1'b1);
      drive(2, 32'hC000_0000 + 32'(k), 1'b1);
      @(negedge clk_user);
      if (!Output_V_V_ap_ack[0]) stall0++;
      if (Output_V_V_ap_ack[1]) k++;
      tick();
      if (!vld_user2interface[0]) gaps++;
    end
    drive(1, '0, 1'b0);
    drive(2, '0, 1'b0);
    tick();
    tick();
    check("indep_ch0_stalls", 32'(stall0), 32'd0);
    check("indep_ch0_gaps", 32'(gaps), 32'd0);
    check("indep_ch0_cnt", 32'(out_xfer_count[3:0]), 32'd8);
    check("indep_ch0_queue", 32'(exp_o0_q.size()), 32'd0);
    check("indep_ch1_held", 32'(k), 32'd4);
    check("indep_ch1_ack", 32'(Output_V_V_ap_ack[1]), 32'd0);
    check("indep_ch1_vld", 32'(vld_user2interface[1]), 32'd1);
    check("indep_ch1_head", din_leaf_user2interface[63:32], 32'hC000_0000);
    check("indep_ch1_cnt", 32'(out_xfer_count[7:4]), 32'd0);
    ack_interface2user = 2'b11;
    for (int j = 0; j < 6; j++) tick();
    check("indep_ch1_queue", 32'(exp_o1_q.size()), 32'd0);
    check("indep_ch1_cnt_after", 32'(out_xfer_count[7:4]), 32'd4);

    // Counter saturation on output channel 0
    pulse_reset();
    stream(1, 32'hD000_0000, 10, gaps);
    tick();
    tick();
    check("sat_cnt_10", 32'(out_xfer_count[3:0]), sat(10));
    stream(1, 32'hD000_000A, 10, gaps);
    tick();
    tick();
    check("sat_cnt_20", 32'(out_xfer_count[3:0]), sat(20));
    check("sat_queue", 32'(exp_o0_q.size()), 32'd0);

    // Reset with words buffered mid-operation
    Input_V_V_ap_ack = 1'b1;
    send(0, 32'hE000_0000);
    send(0, 32'hE000_0001);
    drive(0, '0, 1'b0);
    tick();
    check("mid_cnt_pre", 32'(in_xfer_count), 32'd2);
    Input_V_V_ap_ack = 1'b0;
    send(0, 32'hE100_0001);
    send(0, 32'hE100_0002);
    send(0, 32'hE100_0003);
    drive(0, '0, 1'b0);
    check("mid_vld_pre", 32'(Input_V_V_ap_vld), 32'd1);
    reset = 1'b1;
    exp_in_q.delete();
    exp_o0_q.delete();
    exp_o1_q.delete();
    #1;
    check("mid_rst_vld", 32'(Input_V_V_ap_vld), 32'd0);
    check("mid_rst_ack", 32'(ack_user2interface), 32'd0);
    check("mid_rst_cnt_in", 32'(in_xfer_count), 32'd0);
    check("mid_rst_cnt_out", 32'(out_xfer_count), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    Input_V_V_ap_ack = 1'b1;
    send(0, 32'hA5A5_A5A5);
    drive(0, '0, 1'b0);
    tick();
    tick();
    check("mid_queue", 32'(exp_in_q.size()), 32'd0);
    check("mid_cnt_post", 32'(in_xfer_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
